// File: rtl/control_unit.sv
// ID-stage instruction decoder: maps mode/opcode/S to ALU command and enables.
// Ports: clk, rst (unused by decode), mode, opcode, S -> S_UpdateSig, branch,
//        exeCMD, memWriteEn, memReadEn, writeBackEn (all combinational).
module control_unit (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] mode,
   input  logic [3:0] opcode,
   input  logic       S,
   output logic       S_UpdateSig,
   output logic       branch,
   output logic [3:0] exeCMD,
   output logic       memWriteEn,
   output logic       memReadEn,
   output logic       writeBackEn
);

   typedef enum logic [1:0] {
      MODE_DP  = 2'b00,
      MODE_MEM = 2'b01,
      MODE_BR  = 2'b10
   } mode_e;

   typedef enum logic [3:0] {
      OP_AND = 4'b0000,
      OP_EOR = 4'b0001,
      OP_SUB = 4'b0010,
      OP_ADD = 4'b0100,
      OP_ADC = 4'b0101,
      OP_SBC = 4'b0110,
      OP_TST = 4'b1000,
      OP_CMP = 4'b1010,
      OP_ORR = 4'b1100,
      OP_MOV = 4'b1101,
      OP_MVN = 4'b1111
   } op_e;

   typedef struct packed {
      logic       s_upd;
      logic       br;
      logic [3:0] cmd;
      logic       mem_w;
      logic       mem_r;
      logic       wb;
   } ctrl_t;

   ctrl_t ctrl;
   ctrl_t dp;

   // Clock and reset have no role in a pure decode; keep them visibly consumed.
   logic unused_clk_rst;
   assign unused_clk_rst = clk ^ rst;

   // Data-processing sub-decode; ALU ops write back and follow S,
   // compares only update flags.
   always_comb begin
      dp = '0;
      unique case (opcode)
         OP_MOV:  dp = '{S,    1'b0, 4'b0001, 1'b0, 1'b0, 1'b1};
         OP_MVN:  dp = '{S,    1'b0, 4'b1001, 1'b0, 1'b0, 1'b1};
         OP_ADD:  dp = '{S,    1'b0, 4'b0010, 1'b0, 1'b0, 1'b1};
         OP_ADC:  dp = '{S,    1'b0, 4'b0011, 1'b0, 1'b0, 1'b1};
         OP_SUB:  dp = '{S,    1'b0, 4'b0100, 1'b0, 1'b0, 1'b1};
         OP_SBC:  dp = '{S,    1'b0, 4'b0101, 1'b0, 1'b0, 1'b1};
         OP_AND:  dp = '{S,    1'b0, 4'b0110, 1'b0, 1'b0, 1'b1};
         OP_ORR:  dp = '{S,    1'b0, 4'b0111, 1'b0, 1'b0, 1'b1};
         OP_EOR:  dp = '{S,    1'b0, 4'b1000, 1'b0, 1'b0, 1'b1};
         OP_CMP:  dp = '{1'b1, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b0};
         OP_TST:  dp = '{1'b1, 1'b0, 4'b0110, 1'b0, 1'b0, 1'b0};
         default: dp = '0;
      endcase
   end

   always_comb begin
      ctrl = '0;
      unique case (mode)
         MODE_DP:  ctrl = dp;
         MODE_MEM: begin
            // Only the add-offset form is a legal load/store; S picks direction.
            if (opcode == OP_ADD) begin
               ctrl.cmd   = 4'b0010;
               ctrl.mem_r = S;
               ctrl.wb    = S;
               ctrl.mem_w = ~S;
            end
         end
         MODE_BR:  ctrl.br = 1'b1;
         default:  ctrl = '0;
      endcase
   end

   assign S_UpdateSig = ctrl.s_upd;
   assign branch      = ctrl.br;
   assign exeCMD      = ctrl.cmd;
   assign memWriteEn  = ctrl.mem_w;
   assign memReadEn   = ctrl.mem_r;
   assign writeBackEn = ctrl.wb;

endmodule

// File: tb/tb_control_unit.sv
// Directed and exhaustive checks of the control_unit decode table.
// Output vector order: {S_UpdateSig, branch, exeCMD, memWriteEn, memReadEn, writeBackEn}.
module tb_control_unit;

   logic       clk = 1'b0;
   logic       clk_run = 1'b0;
   logic       rst = 1'b0;
   logic [1:0] mode = 2'b11;
   logic [3:0] opcode = 4'b0000;
   logic       S = 1'b0;
   logic       S_UpdateSig;
   logic       branch;
   logic [3:0] exeCMD;
   logic       memWriteEn;
   logic       memReadEn;
   logic       writeBackEn;

   int checks = 0;
   int errors = 0;

   control_unit dut (
      .clk        (clk),
      .rst        (rst),
      .mode       (mode),
      .opcode     (opcode),
      .S          (S),
      .S_UpdateSig(S_UpdateSig),
      .branch     (branch),
      .exeCMD     (exeCMD),
      .memWriteEn (memWriteEn),
      .memReadEn  (memReadEn),
      .writeBackEn(writeBackEn)
   );

   always #5 if (clk_run) clk = ~clk; else clk = clk;

   function automatic logic [8:0] outs();
      return {S_UpdateSig, branch, exeCMD, memWriteEn, memReadEn, writeBackEn};
   endfunction

   // Reference decode table, written from the instruction-set definition.
   function automatic logic [8:0] ref_dec(input logic [1:0] m,
                                          input logic [3:0] o,
                                          input logic s);
      logic [8:0] r;
      r = 9'b0;
      if (m == 2'b00) begin
         case (o)
            4'b1101: r = {s,    1'b0, 4'b0001, 3'b001};
            4'b1111: r = {s,    1'b0, 4'b1001, 3'b001};
            4'b0100: r = {s,    1'b0, 4'b0010, 3'b001};
            4'b0101: r = {s,    1'b0, 4'b0011, 3'b001};
            4'b0010: r = {s,    1'b0, 4'b0100, 3'b001};
            4'b0110: r = {s,    1'b0, 4'b0101, 3'b001};
            4'b0000: r = {s,    1'b0, 4'b0110, 3'b001};
            4'b1100: r = {s,    1'b0, 4'b0111, 3'b001};
            4'b0001: r = {s,    1'b0, 4'b1000, 3'b001};
            4'b1010: r = {1'b1, 1'b0, 4'b0100, 3'b000};
            4'b1000: r = {1'b1, 1'b0, 4'b0110, 3'b000};
            default: r = 9'b0;
         endcase
      end else if (m == 2'b01) begin
         if (o == 4'b0100)
            r = s ? {2'b00, 4'b0010, 3'b011} : {2'b00, 4'b0010, 3'b100};
      end else if (m == 2'b10) begin
         r = {1'b0, 1'b1, 4'b0000, 3'b000};
      end
      return r;
   endfunction

   task automatic check(input string tag, input logic [8:0] got,
                        input logic [8:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   task automatic apply(input logic [1:0] m, input logic [3:0] o,
                        input logic s);
      mode = m;
      opcode = o;
      S = s;
      #1;
   endtask

   task automatic check_inv(input string tag);
      check({tag, " rd_wr"}, {8'b0, memReadEn & memWriteEn}, 9'b0);
      check({tag, " br_excl"},
            {8'b0, branch & (memReadEn | memWriteEn | writeBackEn | S_UpdateSig)},
            9'b0);
      check({tag, " wr_wb"}, {8'b0, memWriteEn & writeBackEn}, 9'b0);
   endtask

   logic [3:0] bad_dp [5] = '{4'b0011, 4'b0111, 4'b1001, 4'b1011, 4'b1110};

   initial begin
      apply(2'b11, 4'b0000, 1'b0);
      check("reset_idle", outs(), 9'b0_0_0000_000);
      apply(2'b00, 4'b1101, 1'b1);
      check("mov_s1", outs(), 9'b1_0_0001_001);
      apply(2'b00, 4'b0010, 1'b0);
      check("sub_s0", outs(), 9'b0_0_0100_001);
      apply(2'b00, 4'b1010, 1'b0);
      check("cmp_s0", outs(), 9'b1_0_0100_000);
      apply(2'b00, 4'b1000, 1'b0);
      check("tst_s0", outs(), 9'b1_0_0110_000);
      apply(2'b00, 4'b1111, 1'b0);
      check("mvn_s0", outs(), 9'b0_0_1001_001);
      apply(2'b00, 4'b0001, 1'b1);
      check("eor_s1", outs(), 9'b1_0_1000_001);
      for (int i = 0; i < 5; i++)
         for (int s = 0; s < 2; s++) begin
            apply(2'b00, bad_dp[i], s[0]);
            check($sformatf("dp_bad_%b_%0d", bad_dp[i], s), outs(), 9'b0);
         end
      for (int o = 0; o < 16; o++)
         for (int s = 0; s < 2; s++) begin
            apply(2'b11, o[3:0], s[0]);
            check($sformatf("mode3_%0d_%0d", o, s), outs(), 9'b0);
         end
      apply(2'b01, 4'b0100, 1'b1);
      check("ldr", outs(), 9'b0_0_0010_011);
      apply(2'b01, 4'b0100, 1'b0);
      check("str", outs(), 9'b0_0_0010_100);
      apply(2'b01, 4'b0000, 1'b1);
      check("mem_bad_0", outs(), 9'b0);
      apply(2'b01, 4'b1101, 1'b0);
      check("mem_bad_d", outs(), 9'b0);
      apply(2'b10, 4'b0000, 1'b0);
      check("b_0_0", outs(), 9'b0_1_0000_000);
      apply(2'b10, 4'b0000, 1'b1);
      check("b_0_1", outs(), 9'b0_1_0000_000);
      apply(2'b10, 4'b1111, 1'b0);
      check("b_f_0", outs(), 9'b0_1_0000_000);
      apply(2'b10, 4'b1111, 1'b1);
      check("b_f_1", outs(), 9'b0_1_0000_000);

      clk_run = 1'b1;
      for (int i = 0; i < 128; i++) begin
         logic [6:0] v;
         v = i[6:0];
         @(negedge clk);
         rst = 1'b0;
         apply(v[6:5], v[4:1], v[0]);
         check($sformatf("sweep_%0d", i), outs(), ref_dec(v[6:5], v[4:1], v[0]));
         check_inv($sformatf("inv_%0d", i));
         @(posedge clk);
         rst = 1'b1;
         #1;
         check($sformatf("sweep_rst_%0d", i), outs(),
               ref_dec(v[6:5], v[4:1], v[0]));
         @(posedge clk);
         #1;
         check($sformatf("sweep_rst2_%0d", i), outs(),
               ref_dec(v[6:5], v[4:1], v[0]));
      end
      rst = 1'b0;
      clk_run = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
